// File: rtl/pgm_loader.sv
// Framed byte-stream loader for the program ROM: parses magic/addr/len/payload/checksum,
// streams payload into the ROM write port and gates the core reset until a good image lands.
module pgm_loader #(
  parameter int    ADDR_BUS_WIDTH = 16,
  parameter int    ROM_ADDR_WIDTH = 15,
  parameter logic [7:0] MAGIC     = 8'hA5,
  parameter int    RELEASE_DELAY  = 4,
  parameter string HOLD_ON_RESET  = "TRUE"
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [7:0]                byte_i,
  input  logic                      byte_valid_i,
  output logic                      byte_ready_o,
  output logic [ADDR_BUS_WIDTH-1:0] pgm_addr_write_o,
  output logic [7:0]                pgm_data_write_o,
  output logic                      pgm_write_o,
  output logic                      core_rst_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [1:0]                err_o
);

  typedef enum logic [3:0] {
    IDLE, ADDR_L, ADDR_H, LEN_L, LEN_H, DATA, CSUM, RELEASE, DONE, ERR
  } state_t;

  localparam logic [16:0] ROM_BYTES = 17'(1) << ROM_ADDR_WIDTH;
  localparam bit          HOLD      = (HOLD_ON_RESET == "TRUE");
  localparam logic [7:0]  DELAY     = 8'(RELEASE_DELAY);

  state_t      state;
  logic [7:0]  sum, rel_cnt;
  logic [15:0] ptr, len_r, rem;

  logic        accept;
  logic [7:0]  sum_nx;
  logic [15:0] len_full;
  logic [16:0] end_addr;

  assign accept   = byte_valid_i & byte_ready_o;
  assign sum_nx   = sum + byte_i;
  assign len_full = {byte_i, len_r[7:0]};
  assign end_addr = {1'b0, ptr} + {1'b0, len_full};

  assign byte_ready_o = (state != RELEASE);
  assign busy_o       = (state != IDLE) && (state != DONE) && (state != ERR);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state            <= HOLD ? IDLE : RELEASE;
      rel_cnt          <= DELAY;
      sum              <= '0;
      ptr              <= '0;
      len_r            <= '0;
      rem              <= '0;
      pgm_addr_write_o <= '0;
      pgm_data_write_o <= '0;
      pgm_write_o      <= 1'b0;
      core_rst_o       <= 1'b1;
      done_o           <= 1'b0;
      err_o            <= 2'd0;
    end else begin
      pgm_write_o <= 1'b0;
      if (state == RELEASE) begin
        // Release on the last count so it lands exactly RELEASE_DELAY edges after the checksum.
        if (rel_cnt <= 8'd1) begin
          core_rst_o <= 1'b0;
          done_o     <= 1'b1;
          state      <= DONE;
        end else begin
          rel_cnt <= rel_cnt - 8'd1;
        end
      end else if (accept) begin
        sum <= sum_nx;
        case (state)
          IDLE, DONE, ERR: begin
            if (byte_i == MAGIC) begin
              state      <= ADDR_L;
              core_rst_o <= 1'b1;
              done_o     <= 1'b0;
              err_o      <= 2'd0;
              sum        <= '0;
            end
          end
          ADDR_L: begin
            ptr[7:0] <= byte_i;
            state    <= ADDR_H;
          end
          ADDR_H: begin
            ptr[15:8] <= byte_i;
            state     <= LEN_L;
          end
          LEN_L: begin
            len_r[7:0] <= byte_i;
            state      <= LEN_H;
          end
          LEN_H: begin
            len_r <= len_full;
            rem   <= len_full;
            // 17-bit sum so a start near the top of the 16-bit space cannot wrap past the check.
            if (end_addr > ROM_BYTES) begin
              state <= ERR;
              err_o <= 2'd1;
            end else if (len_full == 16'd0) begin
              state <= CSUM;
            end else begin
              state <= DATA;
            end
          end
          DATA: begin
            pgm_write_o      <= 1'b1;
            pgm_addr_write_o <= ADDR_BUS_WIDTH'(ptr);
            pgm_data_write_o <= byte_i;
            ptr              <= ptr + 16'd1;
            rem              <= rem - 16'd1;
            if (rem == 16'd1) state <= CSUM;
          end
          CSUM: begin
            if (sum_nx == 8'd0) begin
              state   <= RELEASE;
              rel_cnt <= DELAY;
            end else begin
              state <= ERR;
              err_o <= 2'd2;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pgm_loader.sv
// Bench for pgm_loader: spec vectors from a table, randomized frames against a frame-level
// model, and hand-written reset / garbage sequences.
module tb_pgm_loader;
  localparam int D = 4;
  localparam logic [7:0] MAGIC = 8'hA5;

  logic        clk = 0, rst = 1;
  logic [7:0]  byte_i = 0;
  logic        byte_valid = 0, byte_ready;
  logic [15:0] waddr;
  logic [7:0]  wdata;
  logic        wstb, core_rst, busy, done;
  logic [1:0]  err;

  pgm_loader #(.ADDR_BUS_WIDTH(16), .ROM_ADDR_WIDTH(15), .MAGIC(MAGIC),
               .RELEASE_DELAY(D), .HOLD_ON_RESET("TRUE")) dut (
    .clk_i(clk), .rst_i(rst), .byte_i(byte_i), .byte_valid_i(byte_valid),
    .byte_ready_o(byte_ready), .pgm_addr_write_o(waddr), .pgm_data_write_o(wdata),
    .pgm_write_o(wstb), .core_rst_o(core_rst), .busy_o(busy), .done_o(done), .err_o(err));

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  logic [23:0] got[$];

  always @(negedge clk) if (wstb) got.push_back({waddr, wdata});

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gaps);
    int n;
    repeat (gaps) begin @(negedge clk); byte_valid = 0; end
    @(negedge clk);
    byte_i = b; byte_valid = 1; n = 0;
    while (!byte_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("send_timeout", 32'(n), 0);
    @(posedge clk);
  endtask

  // Frame-level model: outcome depends only on range fit and checksum validity.
  function automatic logic [1:0] ref_err(input logic [15:0] st, input logic [15:0] ln, input bit bad);
    if (int'(st) + int'(ln) > 32768) return 2'd1;
    return bad ? 2'd2 : 2'd0;
  endfunction

  task automatic run_frame(input string nm, input logic [15:0] st, input logic [15:0] ln,
                           input logic [7:0] pl[$], input bit bad, input bit gaps,
                           input logic [1:0] xerr, input int xwr);
    logic [7:0] hdr[4];
    logic [7:0] s, c;
    bit ok;
    int nbad;
    got.delete();
    send(MAGIC, 0);
    #1 chk({nm, ":magic"}, {30'd0, core_rst, done}, 32'b10);
    hdr = '{st[7:0], st[15:8], ln[7:0], ln[15:8]};
    s = 0;
    foreach (hdr[i]) begin send(hdr[i], 0); s += hdr[i]; end
    if (xerr != 2'd1) begin
      foreach (pl[i]) begin send(pl[i], gaps ? int'($urandom_range(0, 2)) : 0); s += pl[i]; end
      c = 8'd0 - s;
      if (bad) c = c - 8'd1;
      send(c, 0);
    end
    ok = 1;
    for (int k = 1; k <= D + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        byte_valid = 0;
        chk({nm, ":err"}, 32'(err), 32'(xerr));
      end
      if (xerr == 0 && k <= D) begin
        if (core_rst !== 1 || done !== 0 || byte_ready !== 0) ok = 0;
      end else if (xerr == 0) begin
        if (core_rst !== 0 || done !== 1 || byte_ready !== 1 || busy !== 0) ok = 0;
      end else begin
        if (core_rst !== 1 || done !== 0 || byte_ready !== 1 || busy !== 0) ok = 0;
      end
    end
    chk({nm, ":release_timing"}, 32'(ok), 1);
    chk({nm, ":nwrites"}, 32'(got.size()), 32'(xwr));
    nbad = 0;
    for (int k = 0; k < xwr; k++)
      if (k >= got.size() || got[k] !== {16'(st + 16'(k)), pl[k]}) nbad++;
    chk({nm, ":wcontent"}, 32'(nbad), 0);
  endtask

  typedef struct {
    string       nm;
    logic [15:0] start;
    logic [15:0] len;
    logic [7:0]  p0;
    bit          bad;
    logic [1:0]  exp_err;
    int          exp_wr;
  } vec_t;

  initial begin
    vec_t vt[7];
    logic [7:0] pl[$];
    logic [15:0] st, ln;
    bit bad;
    logic [1:0] xe;

    vt[0] = '{"good4",     16'h0000, 16'h0004, 8'h13, 0, 2'd0, 4};
    vt[1] = '{"badsum",    16'h0000, 16'h0004, 8'h13, 1, 2'd2, 4};
    vt[2] = '{"zerolen",   16'h0010, 16'h0000, 8'h00, 0, 2'd0, 0};
    vt[3] = '{"overflow",  16'h7F00, 16'h0200, 8'h00, 0, 2'd1, 0};
    vt[4] = '{"exactfit",  16'h7FFC, 16'h0004, 8'h5C, 0, 2'd0, 4};
    vt[5] = '{"overby1",   16'h7FFD, 16'h0004, 8'h00, 0, 2'd1, 0};
    vt[6] = '{"lastbyte",  16'h7FFF, 16'h0001, 8'hA5, 0, 2'd0, 1};

    #12;
    chk("rst:ready", 32'(byte_ready), 1);
    chk("rst:addr", 32'(waddr), 0);
    chk("rst:data", 32'(wdata), 0);
    chk("rst:wstb", 32'(wstb), 0);
    chk("rst:core_rst", 32'(core_rst), 1);
    chk("rst:busy", 32'(busy), 0);
    chk("rst:done", 32'(done), 0);
    chk("rst:err", 32'(err), 0);
    @(negedge clk); rst = 0;

    // Garbage before the first frame must be dropped without writes or leaving IDLE.
    got.delete();
    send(8'h00, 0); send(8'hFF, 0); send(8'h5A, 0);
    @(negedge clk); byte_valid = 0;
    chk("garbage:busy", 32'(busy), 0);
    chk("garbage:nwrites", 32'(got.size()), 0);

    for (int v = 0; v < 7; v++) begin
      pl.delete();
      for (int i = 0; i < int'(vt[v].len) && i < 16; i++) pl.push_back(i == 0 ? vt[v].p0 : 8'h00);
      run_frame(vt[v].nm, vt[v].start, vt[v].len, pl, vt[v].bad, 0, vt[v].exp_err, vt[v].exp_wr);
    end

    for (int f = 0; f < 30; f++) begin
      st = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(32750, 32767))
                                       : 16'($urandom_range(0, 32767));
      ln = 16'($urandom_range(0, 12));
      bad = ($urandom_range(0, 3) == 0);
      xe = ref_err(st, ln, bad);
      pl.delete();
      for (int i = 0; i < int'(ln); i++) pl.push_back(8'($urandom));
      run_frame($sformatf("rand%0d", f), st, ln, pl, bad, 1, xe, (xe == 2'd1) ? 0 : int'(ln));
    end

    // Reset in the middle of a payload: outputs drop immediately, later bytes are ignored.
    got.delete();
    send(MAGIC, 0); send(8'h00, 0); send(8'h01, 0); send(8'h04, 0); send(8'h00, 0);
    send(8'h21, 0); send(8'h22, 0);
    @(negedge clk);
    #1 rst = 1;
    #1;
    chk("midrst:outs", {23'd0, wstb, byte_ready, core_rst, busy, done, err, 1'b0},
        {23'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0});
    chk("midrst:addr_data", {waddr, wdata}, 0);
    #1 rst = 0;
    send(8'h23, 0); send(8'h24, 0); send(8'h10, 0);
    @(negedge clk); byte_valid = 0;
    repeat (3) @(negedge clk);
    chk("midrst:nwrites", 32'(got.size()), 2);
    chk("midrst:after", {29'd0, busy, core_rst, done}, 32'b010);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
